// File: rtl/ddr_single_access.sv
// Single-word DDR3 debug access engine in the MIG ui_clk domain.
// Arbitrates for the app port, then runs one masked write or one read and pulses done.
module ddr_single_access #(
    parameter int pAPP_DATA_WIDTH = 128,
    parameter int pLANE_LSB       = 3,
    parameter int pTIMEOUT        = 1023
) (
    input  logic                           ui_clk,
    input  logic                           reset_n,
    input  logic                           ddr_single_write,
    input  logic                           ddr_single_read,
    input  logic [29:0]                    ddr_single_address,
    input  logic [63:0]                    ddr_single_write_data,
    output logic [63:0]                    ddr_single_read_data,
    output logic                           ddr_single_done,
    output logic                           O_timeout,
    output logic                           O_arb_req,
    input  logic                           I_arb_grant,
    output logic [29:0]                    app_addr,
    output logic [2:0]                     app_cmd,
    output logic                           app_en,
    input  logic                           app_rdy,
    output logic [pAPP_DATA_WIDTH-1:0]     app_wdf_data,
    output logic [pAPP_DATA_WIDTH/8-1:0]   app_wdf_mask,
    output logic                           app_wdf_wren,
    output logic                           app_wdf_end,
    input  logic                           app_wdf_rdy,
    input  logic [pAPP_DATA_WIDTH-1:0]     app_rd_data,
    input  logic                           app_rd_data_valid
);

    localparam int NLANES    = pAPP_DATA_WIDTH / 64;
    localparam int LANE_BITS = $clog2(NLANES);
    localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int CNT_W     = $clog2(pTIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(pTIMEOUT - 1);
    localparam logic [29:0]      ADDR_KEEP = ~((30'd1 << (pLANE_LSB + LANE_BITS)) - 30'd1);
    localparam logic [2:0]       CMD_WR    = 3'b000;
    localparam logic [2:0]       CMD_RD    = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WR,
        S_RD_CMD,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t                      state;
    logic                        armed;
    logic                        op_write;
    logic [LANE_W-1:0]           lane;
    logic [LANE_W-1:0]           req_lane;
    logic [CNT_W-1:0]            cnt;
    logic [pAPP_DATA_WIDTH/8-1:0] req_mask;
    logic [63:0]                 lane_word;
    logic                        start_op;
    logic                        timeout_hit;
    logic                        en_next;
    logic                        wren_next;

    assign req_lane    = (NLANES > 1) ? ddr_single_address[pLANE_LSB +: LANE_W] : '0;
    assign start_op    = armed && (ddr_single_write || ddr_single_read);
    assign timeout_hit = (cnt == CNT_LAST);
    // Each half of the write handshake retires independently; the state waits for both.
    assign en_next     = app_en && !app_rdy;
    assign wren_next   = app_wdf_wren && !app_wdf_rdy;

    // Only the addressed 64-bit lane is unmasked; the data is replicated across all lanes.
    always_comb begin
        req_mask = '1;
        for (int i = 0; i < NLANES; i++) begin
            if (LANE_W'(i) == req_lane) req_mask[i*8 +: 8] = 8'h00;
        end
    end

    always_comb begin
        lane_word = app_rd_data[63:0];
        for (int i = 0; i < NLANES; i++) begin
            if (LANE_W'(i) == lane) lane_word = app_rd_data[i*64 +: 64];
        end
    end

    always_ff @(posedge ui_clk) begin
        if (!reset_n) begin
            state                <= S_IDLE;
            armed                <= 1'b1;
            op_write             <= 1'b0;
            lane                 <= '0;
            cnt                  <= '0;
            ddr_single_read_data <= '0;
            ddr_single_done      <= 1'b0;
            O_timeout            <= 1'b0;
            O_arb_req            <= 1'b0;
            app_addr             <= '0;
            app_cmd              <= '0;
            app_en               <= 1'b0;
            app_wdf_data         <= '0;
            app_wdf_mask         <= '1;
            app_wdf_wren         <= 1'b0;
            app_wdf_end          <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so setting it on DONE entry yields a single-cycle pulse.
            ddr_single_done <= 1'b0;
            cnt             <= cnt + CNT_W'(1);
            // Re-arm only after both level requests are seen low, so a held request cannot retrigger.
            if (!ddr_single_write && !ddr_single_read) armed <= 1'b1;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_op) begin
                        armed     <= 1'b0;
                        op_write  <= ddr_single_write;
                        lane      <= req_lane;
                        app_addr  <= ddr_single_address & ADDR_KEEP;
                        app_cmd   <= ddr_single_write ? CMD_WR : CMD_RD;
                        O_timeout <= 1'b0;
                        O_arb_req <= 1'b1;
                        if (ddr_single_write) begin
                            app_wdf_data <= {NLANES{ddr_single_write_data}};
                            app_wdf_mask <= req_mask;
                        end
                        state <= S_ARB;
                    end
                end

                S_ARB: begin
                    if (I_arb_grant) begin
                        cnt    <= '0;
                        app_en <= 1'b1;
                        if (op_write) begin
                            app_wdf_wren <= 1'b1;
                            app_wdf_end  <= 1'b1;
                            state        <= S_WR;
                        end else begin
                            state <= S_RD_CMD;
                        end
                    end else if (timeout_hit) begin
                        O_timeout       <= 1'b1;
                        O_arb_req       <= 1'b0;
                        ddr_single_done <= 1'b1;
                        state           <= S_DONE;
                    end
                end

                S_WR: begin
                    app_en       <= en_next;
                    app_wdf_wren <= wren_next;
                    app_wdf_end  <= wren_next;
                    if (!en_next && !wren_next) begin
                        O_arb_req       <= 1'b0;
                        ddr_single_done <= 1'b1;
                        state           <= S_DONE;
                    end else if (timeout_hit) begin
                        app_en          <= 1'b0;
                        app_wdf_wren    <= 1'b0;
                        app_wdf_end     <= 1'b0;
                        O_timeout       <= 1'b1;
                        O_arb_req       <= 1'b0;
                        ddr_single_done <= 1'b1;
                        state           <= S_DONE;
                    end
                end

                S_RD_CMD: begin
                    if (app_rdy) begin
                        app_en <= 1'b0;
                        cnt    <= '0;
                        state  <= S_RD_WAIT;
                    end else if (timeout_hit) begin
                        app_en          <= 1'b0;
                        O_timeout       <= 1'b1;
                        O_arb_req       <= 1'b0;
                        ddr_single_done <= 1'b1;
                        state           <= S_DONE;
                    end
                end

                S_RD_WAIT: begin
                    if (app_rd_data_valid) begin
                        ddr_single_read_data <= lane_word;
                        O_arb_req            <= 1'b0;
                        ddr_single_done      <= 1'b1;
                        state                <= S_DONE;
                    end else if (timeout_hit) begin
                        O_timeout       <= 1'b1;
                        O_arb_req       <= 1'b0;
                        ddr_single_done <= 1'b1;
                        state           <= S_DONE;
                    end
                end

                S_DONE: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_single_access.sv
// Randomized bench for ddr_single_access: the bench plays arbiter and MIG, and a
// word-addressed memory model supplies read data and expected write/read values.
module tb_ddr_single_access;

    localparam int W   = 128;
    localparam int TMO = 15;

    logic          ui_clk = 1'b0;
    logic          reset_n;
    logic          ddr_single_write;
    logic          ddr_single_read;
    logic [29:0]   ddr_single_address;
    logic [63:0]   ddr_single_write_data;
    logic [63:0]   ddr_single_read_data;
    logic          ddr_single_done;
    logic          O_timeout;
    logic          O_arb_req;
    logic          I_arb_grant;
    logic [29:0]   app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [W-1:0]  app_wdf_data;
    logic [W/8-1:0] app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [W-1:0]  app_rd_data;
    logic          app_rd_data_valid;

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0] mem [int unsigned];

    always #5 ui_clk = ~ui_clk;

    ddr_single_access #(
        .pAPP_DATA_WIDTH(W),
        .pLANE_LSB      (3),
        .pTIMEOUT       (TMO)
    ) dut (
        .ui_clk               (ui_clk),
        .reset_n              (reset_n),
        .ddr_single_write     (ddr_single_write),
        .ddr_single_read      (ddr_single_read),
        .ddr_single_address   (ddr_single_address),
        .ddr_single_write_data(ddr_single_write_data),
        .ddr_single_read_data (ddr_single_read_data),
        .ddr_single_done      (ddr_single_done),
        .O_timeout            (O_timeout),
        .O_arb_req            (O_arb_req),
        .I_arb_grant          (I_arb_grant),
        .app_addr             (app_addr),
        .app_cmd              (app_cmd),
        .app_en               (app_en),
        .app_rdy              (app_rdy),
        .app_wdf_data         (app_wdf_data),
        .app_wdf_mask         (app_wdf_mask),
        .app_wdf_wren         (app_wdf_wren),
        .app_wdf_end          (app_wdf_end),
        .app_wdf_rdy          (app_wdf_rdy),
        .app_rd_data          (app_rd_data),
        .app_rd_data_valid    (app_rd_data_valid)
    );

    task automatic tick;
        @(posedge ui_clk);
        #1;
    endtask

    // Reference model: 16-byte app words, 8-byte lanes.
    function automatic int unsigned word_idx(input logic [29:0] a);
        return int'(a) / 16;
    endfunction

    function automatic int lane_of(input logic [29:0] a);
        return (int'(a) / 8) % 2;
    endfunction

    function automatic logic [29:0] exp_app_addr(input logic [29:0] a);
        return 30'((int'(a) / 16) * 16);
    endfunction

    function automatic logic [15:0] exp_mask(input logic [29:0] a);
        logic [15:0] m;
        for (int b = 0; b < 16; b++) m[b] = ((b / 8) != lane_of(a));
        return m;
    endfunction

    function automatic logic [127:0] peek(input int unsigned idx);
        if (!mem.exists(idx)) mem[idx] = {$urandom, $urandom, $urandom, $urandom};
        return mem[idx];
    endfunction

    task automatic run_write(input logic [29:0] addr, input logic [63:0] data, input int grant_dly,
                             input int en_dly, input int wdf_dly, input bit keep_req, input bit also_read);
        int c, en_acc, wr_acc, last_hs, ln;
        bit got;
        logic [127:0] w;
        ln = lane_of(addr);
        ddr_single_address    = addr;
        ddr_single_write_data = data;
        ddr_single_write      = 1'b1;
        ddr_single_read       = also_read;
        tick;
        vectors++;
        if (O_arb_req !== 1'b1 || O_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_start: arb_req=%b timeout=%b, expected arb_req=1 timeout=0", O_arb_req, O_timeout);
        end
        if (!keep_req) begin
            ddr_single_write = 1'b0;
            ddr_single_read  = 1'b0;
        end
        repeat (grant_dly) tick;
        I_arb_grant = 1'b1;
        tick;
        I_arb_grant = 1'b0;
        vectors++;
        if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_cmd !== 3'b000 ||
            app_addr !== exp_app_addr(addr) || O_arb_req !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_cmd: en=%b wren=%b end=%b cmd=%b addr=%h arb=%b, expected 1 1 1 000 %h 1",
                     app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr, O_arb_req, exp_app_addr(addr));
        end
        vectors++;
        if (app_wdf_data !== {data, data} || app_wdf_mask !== exp_mask(addr)) begin
            miscompares++;
            $display("FAIL wr_data: data=%h mask=%h, expected data=%h mask=%h",
                     app_wdf_data, app_wdf_mask, {data, data}, exp_mask(addr));
        end
        c = 0; en_acc = 0; wr_acc = 0; last_hs = -10; got = 1'b0;
        while (!got && c < 40) begin
            if (ddr_single_done === 1'b1) begin
                got = 1'b1;
            end else begin
                app_rdy     = (c >= en_dly);
                app_wdf_rdy = (c >= wdf_dly);
                if (app_en && app_rdy) begin en_acc++; last_hs = c; end
                if (app_wdf_wren && app_wdf_rdy) begin wr_acc++; last_hs = c; end
                tick;
                c++;
            end
        end
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        vectors++;
        if (!got || en_acc != 1 || wr_acc != 1 || last_hs != c - 1) begin
            miscompares++;
            $display("FAIL wr_handshake: done_seen=%b cmd_accepts=%0d data_accepts=%0d done_cycle=%0d last_hs=%0d, expected 1 1 1 and done one cycle after last_hs",
                     got, en_acc, wr_acc, c, last_hs);
        end
        vectors++;
        if (O_arb_req !== 1'b0 || O_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_release: arb_req=%b timeout=%b, expected 0 0", O_arb_req, O_timeout);
        end
        w = peek(word_idx(addr));
        w[ln*64 +: 64] = data;
        mem[word_idx(addr)] = w;
        tick;
        vectors++;
        if (ddr_single_done !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done_width: done=%b one cycle later, expected 0", ddr_single_done);
        end
    endtask

    task automatic run_read(input logic [29:0] addr, input int grant_dly, input int rdy_dly,
                            input int lat, input bit keep_req, input bit extra_beat);
        logic [127:0] w;
        logic [63:0]  exp;
        int c, ln;
        bit acc, early;
        ln  = lane_of(addr);
        w   = peek(word_idx(addr));
        exp = w[ln*64 +: 64];
        ddr_single_address = addr;
        ddr_single_read    = 1'b1;
        tick;
        vectors++;
        if (O_arb_req !== 1'b1 || O_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_start: arb_req=%b timeout=%b, expected arb_req=1 timeout=0", O_arb_req, O_timeout);
        end
        if (!keep_req) ddr_single_read = 1'b0;
        repeat (grant_dly) tick;
        I_arb_grant = 1'b1;
        tick;
        I_arb_grant = 1'b0;
        vectors++;
        if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== exp_app_addr(addr) || app_wdf_wren !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_cmd: en=%b cmd=%b addr=%h wren=%b, expected 1 001 %h 0",
                     app_en, app_cmd, app_addr, app_wdf_wren, exp_app_addr(addr));
        end
        c = 0; acc = 1'b0;
        while (!acc && c < 20) begin
            app_rdy = (c >= rdy_dly);
            if (app_en && app_rdy) acc = 1'b1;
            tick;
            c++;
        end
        app_rdy = 1'b0;
        early = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (app_en !== 1'b0 || ddr_single_done !== 1'b0) early = 1'b1;
            tick;
        end
        vectors++;
        if (!acc || early || app_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_wait: accepted=%b early_activity=%b en=%b, expected 1 0 0", acc, early, app_en);
        end
        app_rd_data       = w;
        app_rd_data_valid = 1'b1;
        tick;
        if (extra_beat) app_rd_data = ~w;
        else app_rd_data_valid = 1'b0;
        vectors++;
        if (ddr_single_done !== 1'b1 || ddr_single_read_data !== exp) begin
            miscompares++;
            $display("FAIL rd_done: done=%b data=%h, expected 1 %h", ddr_single_done, ddr_single_read_data, exp);
        end
        tick;
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        vectors++;
        if (ddr_single_done !== 1'b0 || ddr_single_read_data !== exp || O_arb_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_after: done=%b data=%h arb=%b, expected 0 %h 0",
                     ddr_single_done, ddr_single_read_data, O_arb_req, exp);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) tick;
        vectors++;
        if (ddr_single_done !== 1'b0 || O_timeout !== 1'b0 || O_arb_req !== 1'b0 || app_en !== 1'b0 ||
            app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0 || app_cmd !== 3'b000 || app_addr !== 30'd0 ||
            app_wdf_data !== '0 || app_wdf_mask !== 16'hFFFF || ddr_single_read_data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_state: done=%b to=%b arb=%b en=%b wren=%b end=%b cmd=%b addr=%h wdata=%h mask=%h rdata=%h, expected zeros with mask ffff",
                     ddr_single_done, O_timeout, O_arb_req, app_en, app_wdf_wren, app_wdf_end, app_cmd,
                     app_addr, app_wdf_data, app_wdf_mask, ddr_single_read_data);
        end
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_directed_write;
        run_write(30'h0000_0008, 64'h1122_3344_5566_7788, 0, 0, 0, 1'b0, 1'b0);
        vectors++;
        if (mem[0][127:64] !== 64'h1122_3344_5566_7788) begin
            miscompares++;
            $display("FAIL directed_write_model: upper lane=%h, expected 1122334455667788", mem[0][127:64]);
        end
    endtask

    task automatic test_directed_read;
        mem[1] = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
        run_read(30'h0000_0010, 0, 0, 5, 1'b0, 1'b1);
        vectors++;
        if (ddr_single_read_data !== 64'h5555_5555_5555_5555) begin
            miscompares++;
            $display("FAIL directed_read: data=%h, expected 5555555555555555", ddr_single_read_data);
        end
    endtask

    task automatic test_wdf_stall;
        run_write(30'h0000_0130, 64'hDEAD_BEEF_0BAD_F00D, 1, 0, 5, 1'b0, 1'b0);
        run_write(30'h0000_0138, 64'h0123_4567_89AB_CDEF, 0, 4, 0, 1'b0, 1'b0);
        run_read(30'h0000_0130, 0, 2, 1, 1'b0, 1'b0);
        run_read(30'h0000_0138, 2, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_held_request;
        bit quiet;
        run_read(30'h0000_0048, 0, 1, 3, 1'b1, 1'b0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (O_arb_req !== 1'b0 || app_en !== 1'b0 || ddr_single_done !== 1'b0) quiet = 1'b1 & 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL held_request: activity seen while request held, expected none");
        end
        ddr_single_read = 1'b0;
        tick;
        run_read(30'h0000_0040, 1, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        logic [63:0] prev;
        int n;
        prev = ddr_single_read_data;
        ddr_single_address = 30'h0000_0220;
        ddr_single_read    = 1'b1;
        tick;
        ddr_single_read = 1'b0;
        I_arb_grant     = 1'b1;
        tick;
        I_arb_grant = 1'b0;
        app_rdy     = 1'b1;
        tick;
        app_rdy = 1'b0;
        n = 0;
        while (ddr_single_done !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        vectors++;
        if (n != TMO || O_timeout !== 1'b1 || ddr_single_read_data !== prev || app_en !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: wait_cycles=%0d to=%b data=%h en=%b, expected %0d 1 %h 0",
                     n, O_timeout, ddr_single_read_data, app_en, TMO, prev);
        end
        tick;
        vectors++;
        if (ddr_single_done !== 1'b0 || O_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: done=%b to=%b, expected 0 1", ddr_single_done, O_timeout);
        end
    endtask

    task automatic test_reset_mid_op;
        bit quiet;
        ddr_single_address = 30'h0000_0018;
        ddr_single_read    = 1'b1;
        tick;
        ddr_single_read = 1'b0;
        I_arb_grant     = 1'b1;
        tick;
        I_arb_grant = 1'b0;
        app_rdy     = 1'b1;
        tick;
        app_rdy = 1'b0;
        tick;
        reset_n = 1'b0;
        tick;
        vectors++;
        if (ddr_single_done !== 1'b0 || ddr_single_read_data !== 64'd0 || app_en !== 1'b0 ||
            O_arb_req !== 1'b0 || app_wdf_mask !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL reset_mid_op: done=%b data=%h en=%b arb=%b mask=%h, expected 0 0 0 0 ffff",
                     ddr_single_done, ddr_single_read_data, app_en, O_arb_req, app_wdf_mask);
        end
        ddr_single_write = 1'b1;
        ddr_single_read  = 1'b1;
        tick;
        reset_n = 1'b1;
        run_write(30'h0000_0058, 64'hCAFE_F00D_1234_5678, 0, 1, 2, 1'b1, 1'b1);
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (O_arb_req !== 1'b0 || app_en !== 1'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL write_priority: a second op started while both requests held, expected none");
        end
        ddr_single_write = 1'b0;
        ddr_single_read  = 1'b0;
        tick;
        run_read(30'h0000_0058, 0, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [29:0] a;
        for (int k = 0; k < 30; k++) begin
            a = 30'(($urandom_range(0, 1) << 20) | ($urandom_range(0, 3) << 4) |
                    ($urandom_range(0, 1) << 3) | $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                run_write(a, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 5),
                          $urandom_range(0, 5), 1'b0, 1'($urandom_range(0, 1)));
            else
                run_read(a, $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 9),
                         1'b0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n               = 1'b0;
        ddr_single_write      = 1'b0;
        ddr_single_read       = 1'b0;
        ddr_single_address    = '0;
        ddr_single_write_data = '0;
        I_arb_grant           = 1'b0;
        app_rdy               = 1'b0;
        app_wdf_rdy           = 1'b0;
        app_rd_data           = '0;
        app_rd_data_valid     = 1'b0;
        test_reset;
        test_directed_write;
        test_directed_read;
        test_wdf_stall;
        test_held_request;
        test_timeout;
        test_reset_mid_op;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
